uart_cmd_master: RTL and testbench

UART_CMD_MASTER -- requirements
Module: uart_cmd_master

---
 rtl/uart_cmd_pkg.sv | 44 ++++
 rtl/uart_cmd_timeout.sv | 29 ++
 rtl/uart_cmd_master.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_master.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared command codes, response trailer bytes, response-length lookup and FSM encoding
// for the CoreUART command master.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_STATUS  = 8'h06;
    localparam logic [7:0] CMD_ECHO_04 = 8'h04;
    localparam logic [7:0] CMD_ECHO_09 = 8'h09;

    localparam logic [7:0] TRL_PAD = 8'h00;
    localparam logic [7:0] TRL_04  = 8'h0E;
    localparam logic [7:0] TRL_09  = 8'h0F;

    typedef enum logic [2:0] {
        IDLE,
        TX_WR,
        TX_WAIT,
        RX_WAIT,
        RX_ACK,
        DONE
    } state_t;

    function automatic logic [2:0] rsp_len(input logic [7:0] code);
        logic [2:0] len;
        case (code)
            CMD_STATUS:               len = 3'd6;
            CMD_ECHO_04, CMD_ECHO_09: len = 3'd3;
            default:                  len = 3'd0;
        endcase
        return len;
    endfunction

    // Expected fixed byte at response position idx (1 or 2) for the short responses.
    function automatic logic [7:0] trailer_byte(input logic [7:0] code, input logic [2:0] idx);
        logic [7:0] b;
        if (idx == 3'd1)
            b = TRL_PAD;
        else if (code == CMD_ECHO_04)
            b = TRL_04;
        else
            b = TRL_09;
        return b;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte response timer: clear wins over enable, expired is a pure decode of the count.
// Zero latency on expired; the count freezes once expired so it never wraps.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign expired = (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + CW'(1);
    end

endmodule

// File: rtl/uart_cmd_master.sv
// Sends one command byte to a CoreUART and collects its fixed-length response into rsp_*.
// One command in flight; cmd_ready only in IDLE; UART strobes are registered active-low.
module uart_cmd_master #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_code,
    output logic        cmd_ready,
    input  logic        uart_txrdy,
    input  logic        uart_rxrdy,
    input  logic [7:0]  uart_data_in,
    output logic        uart_wen,
    output logic        uart_oen,
    output logic [7:0]  uart_data_out,
    output logic        rsp_valid,
    output logic [7:0]  rsp_code,
    output logic [2:0]  rsp_status,
    output logic [31:0] rsp_err_count,
    output logic        rsp_error,
    output logic        rsp_timeout
);
    import uart_cmd_pkg::*;

    state_t     state, state_nxt;
    logic [2:0] idx;
    logic [2:0] rlen;
    logic       draining;
    logic       wen_nxt, oen_nxt;
    logic       accept, drain_start, capture, ack_done, timeout_hit;
    logic       tmr_clear, tmr_en, tmr_expired;

    // rsp_code doubles as the latched command for the whole transaction
    assign rlen      = rsp_len(rsp_code);
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);

    assign tmr_clear = ((state != RX_WAIT) && (state_nxt == RX_WAIT)) || capture;
    assign tmr_en    = (state == RX_WAIT);

    uart_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            uart_wen <= 1'b1;
            uart_oen <= 1'b1;
        end else begin
            state    <= state_nxt;
            uart_wen <= wen_nxt;
            uart_oen <= oen_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wen_nxt     = uart_wen;
        oen_nxt     = uart_oen;
        accept      = 1'b0;
        drain_start = 1'b0;
        capture     = 1'b0;
        ack_done    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = TX_WR;
                end else if (uart_rxrdy) begin
                    drain_start = 1'b1;
                    oen_nxt     = 1'b0;
                    state_nxt   = RX_ACK;
                end
            end
            TX_WR: begin
                if (uart_txrdy) begin
                    wen_nxt = 1'b0;
                end else begin
                    wen_nxt   = 1'b1;
                    state_nxt = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (uart_txrdy)
                    state_nxt = (rlen != 3'd0) ? RX_WAIT : DONE;
            end
            RX_WAIT: begin
                // a byte arriving on the expiry cycle is still taken
                if (uart_rxrdy) begin
                    capture   = 1'b1;
                    oen_nxt   = 1'b0;
                    state_nxt = RX_ACK;
                end else if (tmr_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = DONE;
                end
            end
            RX_ACK: begin
                if (!uart_rxrdy) begin
                    oen_nxt  = 1'b1;
                    ack_done = 1'b1;
                    if (draining)
                        state_nxt = IDLE;
                    else if (idx + 3'd1 == rlen)
                        state_nxt = DONE;
                    else
                        state_nxt = RX_WAIT;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uart_data_out <= 8'h00;
            rsp_code      <= 8'h00;
            rsp_status    <= 3'b000;
            rsp_err_count <= 32'h0;
            rsp_error     <= 1'b0;
            rsp_timeout   <= 1'b0;
            idx           <= 3'd0;
            draining      <= 1'b0;
        end else begin
            if (accept) begin
                uart_data_out <= cmd_code;
                rsp_code      <= cmd_code;
                rsp_status    <= 3'b000;
                rsp_err_count <= 32'h0;
                rsp_error     <= 1'b0;
                rsp_timeout   <= 1'b0;
                idx           <= 3'd0;
            end
            if (drain_start)
                draining <= 1'b1;
            if (ack_done) begin
                if (draining)
                    draining <= 1'b0;
                else
                    idx <= idx + 3'd1;
            end
            if (capture) begin
                if (idx == 3'd0) begin
                    if (uart_data_in != rsp_code)
                        rsp_error <= 1'b1;
                end else if (rsp_code == CMD_STATUS) begin
                    case (idx)
                        3'd1:    rsp_status           <= uart_data_in[2:0];
                        3'd2:    rsp_err_count[7:0]   <= uart_data_in;
                        3'd3:    rsp_err_count[15:8]  <= uart_data_in;
                        3'd4:    rsp_err_count[23:16] <= uart_data_in;
                        3'd5:    rsp_err_count[31:24] <= uart_data_in;
                        default: ;
                    endcase
                end else if (uart_data_in != trailer_byte(rsp_code, idx)) begin
                    rsp_error <= 1'b1;
                end
            end
            if (timeout_hit)
                rsp_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master: a small CoreUART handshake model plus hand-computed
// expectations for each command, timeout, mid-transaction reset and stray-byte drain.
module tb_uart_cmd_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic        cmd_ready;
    logic        uart_txrdy;
    logic        uart_rxrdy;
    logic [7:0]  uart_data_in;
    logic        uart_wen;
    logic        uart_oen;
    logic [7:0]  uart_data_out;
    logic        rsp_valid;
    logic [7:0]  rsp_code;
    logic [2:0]  rsp_status;
    logic [31:0] rsp_err_count;
    logic        rsp_error;
    logic        rsp_timeout;

    int n_checks = 0;
    int n_errors = 0;

    int   wen_falls    = 0;
    int   oen_falls    = 0;
    int   valid_pulses = 0;
    logic wen_q        = 1'b1;
    logic oen_q        = 1'b1;
    logic valid_q      = 1'b0;
    logic [7:0] tx_byte = 8'h00;

    uart_cmd_master #(.TIMEOUT_CYCLES(100)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_code      (cmd_code),
        .cmd_ready     (cmd_ready),
        .uart_txrdy    (uart_txrdy),
        .uart_rxrdy    (uart_rxrdy),
        .uart_data_in  (uart_data_in),
        .uart_wen      (uart_wen),
        .uart_oen      (uart_oen),
        .uart_data_out (uart_data_out),
        .rsp_valid     (rsp_valid),
        .rsp_code      (rsp_code),
        .rsp_status    (rsp_status),
        .rsp_err_count (rsp_err_count),
        .rsp_error     (rsp_error),
        .rsp_timeout   (rsp_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        wen_q   <= uart_wen;
        oen_q   <= uart_oen;
        valid_q <= rsp_valid;
        if (wen_q && !uart_wen) begin
            wen_falls <= wen_falls + 1;
            tx_byte   <= uart_data_out;
        end
        if (oen_q && !uart_oen)
            oen_falls <= oen_falls + 1;
        if (rsp_valid && !valid_q)
            valid_pulses <= valid_pulses + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [7:0] code);
        cmd_valid = 1'b1;
        cmd_code  = code;
        step();
        cmd_valid = 1'b0;
    endtask

    // Accept one write strobe; optionally raise a response byte while the transmitter is busy.
    task automatic serve_tx(input logic [7:0] exp, input bit early, input logic [7:0] early_byte);
        int n = 0;
        while (uart_wen !== 1'b0 && n < 50) begin
            step();
            n++;
        end
        check("tx_wen_low", {31'b0, uart_wen}, 32'h0);
        check("tx_data", {24'b0, uart_data_out}, {24'b0, exp});
        uart_txrdy = 1'b0;
        if (early) begin
            uart_data_in = early_byte;
            uart_rxrdy   = 1'b1;
        end
        step();
        step();
        step();
        if (early)
            check("rx_pending_during_tx", {31'b0, uart_oen}, 32'h1);
        uart_txrdy = 1'b1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        int n = 0;
        uart_data_in = b;
        uart_rxrdy   = 1'b1;
        while (uart_oen !== 1'b0 && n < 50) begin
            step();
            n++;
        end
        check("rx_oen_low", {31'b0, uart_oen}, 32'h0);
        uart_rxrdy = 1'b0;
        step();
    endtask

    task automatic wait_valid();
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check("rsp_valid_seen", {31'b0, rsp_valid}, 32'h1);
    endtask

    initial begin
        int v0, w0, o0;
        reset        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_code     = 8'h00;
        uart_txrdy   = 1'b1;
        uart_rxrdy   = 1'b0;
        uart_data_in = 8'h00;
        step();
        step();
        check("rst_wen", {31'b0, uart_wen}, 32'h1);
        check("rst_oen", {31'b0, uart_oen}, 32'h1);
        check("rst_data_out", {24'b0, uart_data_out}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_code", {24'b0, rsp_code}, 32'h0);
        check("rst_rsp_status", {29'b0, rsp_status}, 32'h0);
        check("rst_err_count", rsp_err_count, 32'h0);
        check("rst_rsp_error", {31'b0, rsp_error}, 32'h0);
        check("rst_rsp_timeout", {31'b0, rsp_timeout}, 32'h0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        reset = 1'b1;
        step();

        // 0x06 full status response
        v0 = valid_pulses;
        do_cmd(8'h06);
        check("c06_busy", {31'b0, cmd_ready}, 32'h0);
        serve_tx(8'h06, 1'b0, 8'h00);
        rx_byte(8'h06); rx_byte(8'h05); rx_byte(8'h78);
        rx_byte(8'h56); rx_byte(8'h34); rx_byte(8'h12);
        wait_valid();
        check("c06_code", {24'b0, rsp_code}, 32'h06);
        check("c06_status", {29'b0, rsp_status}, 32'h5);
        check("c06_err_count", rsp_err_count, 32'h12345678);
        check("c06_error", {31'b0, rsp_error}, 32'h0);
        check("c06_timeout", {31'b0, rsp_timeout}, 32'h0);
        step();
        check("c06_valid_one_cycle", {31'b0, rsp_valid}, 32'h0);
        check("c06_ready", {31'b0, cmd_ready}, 32'h1);
        check("c06_pulses", valid_pulses - v0, 32'd1);
        check("c06_hold_count", rsp_err_count, 32'h12345678);

        // 0x09 good trailer, echo byte raised while transmitter still busy
        do_cmd(8'h09);
        serve_tx(8'h09, 1'b1, 8'h09);
        rx_byte(8'h09); rx_byte(8'h00); rx_byte(8'h0F);
        wait_valid();
        check("c09_code", {24'b0, rsp_code}, 32'h09);
        check("c09_error", {31'b0, rsp_error}, 32'h0);
        step();

        // 0x04 bad trailer: all three bytes still consumed
        o0 = oen_falls;
        do_cmd(8'h04);
        serve_tx(8'h04, 1'b0, 8'h00);
        rx_byte(8'h04); rx_byte(8'h00);
        check("c04_error_before_bad", {31'b0, rsp_error}, 32'h0);
        rx_byte(8'h0D);
        wait_valid();
        check("c04_error", {31'b0, rsp_error}, 32'h1);
        check("c04_code", {24'b0, rsp_code}, 32'h04);
        step();
        check("c04_oen_count", oen_falls - o0, 32'd3);

        // 0x02 has no response
        w0 = wen_falls; o0 = oen_falls; v0 = valid_pulses;
        do_cmd(8'h02);
        check("c02_error_cleared", {31'b0, rsp_error}, 32'h0);
        serve_tx(8'h02, 1'b0, 8'h00);
        wait_valid();
        step();
        check("c02_wen_windows", wen_falls - w0, 32'd1);
        check("c02_tx_byte", {24'b0, tx_byte}, 32'h02);
        check("c02_no_oen", oen_falls - o0, 32'd0);
        check("c02_pulses", valid_pulses - v0, 32'd1);

        // 0x06 with only two bytes returned: timeout 100 cycles after RX_WAIT re-entry
        v0 = valid_pulses;
        do_cmd(8'h06);
        serve_tx(8'h06, 1'b0, 8'h00);
        rx_byte(8'h06); rx_byte(8'h05);
        for (int k = 1; k < 100; k++)
            step();
        check("to_not_yet", {31'b0, rsp_timeout}, 32'h0);
        step();
        check("to_set", {31'b0, rsp_timeout}, 32'h1);
        check("to_valid", {31'b0, rsp_valid}, 32'h1);
        check("to_status", {29'b0, rsp_status}, 32'h5);
        check("to_err_count", rsp_err_count, 32'h0);
        step();
        check("to_pulses", valid_pulses - v0, 32'd1);

        // reset while in RX_ACK
        do_cmd(8'h06);
        serve_tx(8'h06, 1'b0, 8'h00);
        uart_data_in = 8'h06;
        uart_rxrdy   = 1'b1;
        for (int k = 0; k < 50 && uart_oen !== 1'b0; k++)
            step();
        check("rst_mid_in_ack", {31'b0, uart_oen}, 32'h0);
        v0 = valid_pulses;
        reset = 1'b0;
        #1;
        check("rst_mid_oen", {31'b0, uart_oen}, 32'h1);
        check("rst_mid_wen", {31'b0, uart_wen}, 32'h1);
        check("rst_mid_valid", {31'b0, rsp_valid}, 32'h0);
        uart_rxrdy = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check("rst_rel_ready", {31'b0, cmd_ready}, 32'h1);
        step();
        check("rst_rel_ready_cycle", {31'b0, cmd_ready}, 32'h1);
        check("rst_no_pulse", valid_pulses - v0, 32'd0);

        // stray byte in IDLE
        o0 = oen_falls; v0 = valid_pulses;
        rx_byte(8'hAA);
        step();
        step();
        check("stray_oen_pulses", oen_falls - o0, 32'd1);
        check("stray_no_valid", valid_pulses - v0, 32'd0);
        check("stray_ready", {31'b0, cmd_ready}, 32'h1);
        check("stray_code", {24'b0, rsp_code}, 32'h00);

        // cmd_valid held through the whole transaction
        w0 = wen_falls; v0 = valid_pulses;
        cmd_valid = 1'b1;
        cmd_code  = 8'h09;
        step();
        serve_tx(8'h09, 1'b0, 8'h00);
        rx_byte(8'h09); rx_byte(8'h00); rx_byte(8'h0F);
        wait_valid();
        cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++)
            step();
        check("held_wen_windows", wen_falls - w0, 32'd1);
        check("held_pulses", valid_pulses - v0, 32'd1);
        check("held_ready", {31'b0, cmd_ready}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
